// File: rtl/eth_rx_pkg.sv
// Shared constants and types for the MII receive FCS checker.
// CRC constants describe an MSB-shifting register fed LSB-first bits.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    END
  } rx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_HI_NIB   = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  localparam int BCNT_W = 11;
  localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

endpackage

// File: rtl/eth_crc32_nibble_chk.sv
// Registered CRC32 over one MII nibble per enabled cycle, rxd[0] applied first.
// residue_ok reflects the current register, so it is valid the cycle after the last update.
module eth_crc32_nibble_chk
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [3:0]  d,
  output logic [31:0] crc,
  output logic        residue_ok
);

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [3:0] nib);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 4; i++) begin
      fb = c[31] ^ nib[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_step(crc, d);
    end
  end

  assign residue_ok = (crc == CRC_RESIDUE);

endmodule

// File: rtl/eth_mii_rx_fcs_check.sv
// MII RX: strips preamble/SFD, assembles bytes, checks CRC32 and length, drops the FCS.
// Payload is held 5 bytes deep so the FCS never leaves; status lands the cycle after rx_dv falls.
module eth_mii_rx_fcs_check
  import eth_rx_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mii_rx_dv,
  input  logic                 mii_rx_er,
  input  logic [3:0]           mii_rxd,
  output logic                 m_valid,
  output logic [7:0]           m_data,
  output logic                 m_last,
  output logic                 m_good,
  output logic                 stat_done,
  output logic                 stat_crc_err,
  output logic                 stat_rx_err,
  output logic                 stat_align_err,
  output logic                 stat_runt,
  output logic                 stat_too_long,
  output logic [ERR_CNT_W-1:0] crc_err_cnt
);

  localparam logic [BCNT_W-1:0] MIN_L = BCNT_W'(MIN_FRAME_BYTES);
  localparam logic [BCNT_W-1:0] MAX_L = BCNT_W'(MAX_FRAME_BYTES);

  rx_state_t         state;
  logic              phase;
  logic [3:0]        lo_q;
  logic [39:0]       pipe;
  logic [2:0]        pcnt;
  logic [BCNT_W-1:0] byte_cnt;
  logic              rx_err_q;
  logic [31:0]       crc_state;
  logic [31:0]       byte_crc_q;
  logic              crc_ok;
  logic              crc_init;
  logic              crc_en;

  assign crc_init = (state == PREAMBLE) && mii_rx_dv && (mii_rxd == SFD_HI_NIB);
  assign crc_en   = (state == DATA) && mii_rx_dv;

  eth_crc32_nibble_chk u_crc (
    .clk        (clk),
    .rst        (rst),
    .init       (crc_init),
    .en         (crc_en),
    .d          (mii_rxd),
    .crc        (crc_state),
    .residue_ok (crc_ok)
  );

  // A dangling nibble has already been folded into the live CRC, so judge the
  // frame on the snapshot taken at the last byte boundary instead.
  logic pipe_full, crc_ok_now, f_crc_err, f_rx_err, f_runt, f_too_long, f_good;
  assign pipe_full  = (pcnt == 3'd5);
  assign crc_ok_now = phase ? (byte_crc_q == CRC_RESIDUE) : crc_ok;
  assign f_crc_err  = pipe_full & ~crc_ok_now;
  assign f_rx_err   = rx_err_q | mii_rx_er;
  assign f_runt     = ~pipe_full | (byte_cnt < MIN_L);
  assign f_too_long = (byte_cnt > MAX_L);
  assign f_good     = ~(f_crc_err | f_rx_err | phase | f_runt | f_too_long);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_IDLE;
      phase          <= 1'b0;
      lo_q           <= '0;
      pipe           <= '0;
      pcnt           <= '0;
      byte_cnt       <= '0;
      rx_err_q       <= 1'b0;
      byte_crc_q     <= '0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_last         <= 1'b0;
      m_good         <= 1'b0;
      stat_done      <= 1'b0;
      stat_crc_err   <= 1'b0;
      stat_rx_err    <= 1'b0;
      stat_align_err <= 1'b0;
      stat_runt      <= 1'b0;
      stat_too_long  <= 1'b0;
      crc_err_cnt    <= '0;
    end else begin
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      m_good         <= 1'b0;
      stat_done      <= 1'b0;
      stat_crc_err   <= 1'b0;
      stat_rx_err    <= 1'b0;
      stat_align_err <= 1'b0;
      stat_runt      <= 1'b0;
      stat_too_long  <= 1'b0;
      case (state)
        WAIT_IDLE: if (!mii_rx_dv) state <= IDLE;
        IDLE: if (mii_rx_dv) state <= (mii_rxd == PREAMBLE_NIB) ? PREAMBLE : WAIT_IDLE;
        PREAMBLE: begin
          if (!mii_rx_dv) begin
            state <= IDLE;
          end else if (mii_rxd == SFD_HI_NIB) begin
            state    <= DATA;
            phase    <= 1'b0;
            pcnt     <= '0;
            byte_cnt <= '0;
            rx_err_q <= 1'b0;
          end else if (mii_rxd != PREAMBLE_NIB) begin
            state <= WAIT_IDLE;
          end
        end
        DATA: begin
          if (!phase) byte_crc_q <= crc_state;
          if (mii_rx_er) rx_err_q <= 1'b1;
          if (mii_rx_dv) begin
            phase <= ~phase;
            if (!phase) begin
              lo_q <= mii_rxd;
            end else begin
              pipe <= {pipe[31:0], mii_rxd, lo_q};
              if (pipe_full) begin
                m_valid <= 1'b1;
                m_data  <= pipe[39:32];
              end else begin
                pcnt <= pcnt + 3'd1;
              end
              if (byte_cnt != BCNT_MAX) byte_cnt <= byte_cnt + 1'b1;
            end
          end else begin
            state          <= END;
            stat_done      <= 1'b1;
            stat_crc_err   <= f_crc_err;
            stat_rx_err    <= f_rx_err;
            stat_align_err <= phase;
            stat_runt      <= f_runt;
            stat_too_long  <= f_too_long;
            m_valid        <= pipe_full;
            m_last         <= pipe_full;
            m_good         <= pipe_full & f_good;
            if (pipe_full) m_data <= pipe[39:32];
            if (f_crc_err && !(&crc_err_cnt)) crc_err_cnt <= crc_err_cnt + 1'b1;
          end
        end
        END:     state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_mii_rx_fcs_check.md
Name: eth_mii_rx_fcs_check

Overview:
- Receive-side counterpart of the nibble-wide CRC32 FCS generator on the Ethernet MII datapath.
- Consumes raw MII RX nibbles, strips preamble/SFD, assembles bytes and computes CRC32 over the frame.
- Strips the 4-byte FCS, streams payload bytes to the MAC RX logic, and reports good/bad status on the last byte.

Parameters:
- MIN_FRAME_BYTES, 64, minimum legal length counted from first byte after SFD, FCS included.
- MAX_FRAME_BYTES, 1518, maximum legal length, same counting.
- ERR_CNT_W, 16, width of saturating CRC-error counter.

Ports:
- clk  in  1  MII RX clock; one nibble per cycle.
- rst  in  1  reset; synchronous, active-high.
- mii_rx_dv  in  1  receive data valid.
- mii_rx_er  in  1  receive error.
- mii_rxd  in  4  receive nibble; low nibble of each byte arrives first.
- m_valid  out  1  single-cycle pulse, output byte valid.
- m_data  out  8  payload byte.
- m_last  out  1  with m_valid: last payload byte of frame.
- m_good  out  1  with m_last: frame passed all checks.
- stat_done  out  1  one-cycle pulse per frame end, including frames that emit no byte.
- stat_crc_err  out  1  status flag, valid on stat_done.
- stat_rx_err  out  1  status flag, valid on stat_done.
- stat_align_err  out  1  status flag, valid on stat_done.
- stat_runt  out  1  status flag, valid on stat_done.
- stat_too_long  out  1  status flag, valid on stat_done.
- crc_err_cnt  out  ERR_CNT_W  saturating count of frames with stat_crc_err.

Behaviour:
- Reset: all outputs 0, crc_err_cnt 0, state WAIT_IDLE. Reset mid-frame discards the frame; nothing is emitted for it.
- States:
  - WAIT_IDLE: go to IDLE when rx_dv=0.
  - IDLE: rx_dv=1 and rxd=0x5 -> PREAMBLE. rx_dv=1 with any other nibble -> WAIT_IDLE.
  - PREAMBLE: rxd=0x5 stays. rxd=0xD -> DATA; this completes SFD 0xD5, and a short preamble is accepted. Any other nibble -> WAIT_IDLE. rx_dv=0 -> IDLE, with no stat_done.
  - DATA: alternate low/high nibble, forming one byte per 2 cycles. rx_dv=0 -> END.
  - END: one cycle; report the frame, then -> IDLE.
- CRC:
  - Polynomial 0x04C11DB7, register init 0xFFFFFFFF on SFD detect, MSB-shifting (Galois) form.
  - Each nibble is applied bit by bit, rxd[0] first. The register is updated on every DATA nibble, FCS nibbles included.
  - At END, the frame passes CRC iff the register equals residue 0xC704DD7B.
- Byte delay:
  - Assembled bytes enter a 5-deep byte pipeline.
  - When a byte arrives and the pipeline already holds 5 bytes, the oldest is emitted: m_valid=1, m_last=0, in the cycle after the high nibble is sampled.
  - At END, if the pipeline holds 5 bytes, the oldest is emitted with m_last=1 and m_good. The other 4 bytes are the FCS and are dropped.
  - Fewer than 5 bytes at END: no byte is emitted, stat_runt=1, stat_crc_err=0.
- Timing: rx_dv sampled low in cycle t -> stat_done and the final m_valid/m_last in cycle t+1.
- Length:
  - Byte counter counts from the first byte after SFD and saturates at 2047.
  - stat_runt = count < MIN_FRAME_BYTES.
  - stat_too_long = count > MAX_FRAME_BYTES. Bytes keep streaming and the flag is reported at END.
- stat_rx_err is sticky for the frame if rx_er=1 on any DATA cycle.
- stat_align_err: odd nibble count at END. The dangling nibble is discarded and excluded from the CRC check.
- m_good = no crc, rx, align, runt or too_long error.
- crc_err_cnt increments at END when stat_crc_err=1, saturating at all-ones.
- Status flags are 0 whenever stat_done=0.

Decomposition:
- Package eth_rx_pkg holds:
  - state enum (WAIT_IDLE, IDLE, PREAMBLE, DATA, END);
  - PREAMBLE_NIB=0x5, SFD_HI_NIB=0xD;
  - CRC_POLY, CRC_INIT, CRC_RESIDUE;
  - byte-counter width 11.
- One sub-module: eth_crc32_nibble_chk. It holds the registered CRC with init/enable inputs, a 4-bit data input, a 32-bit state output and a residue_ok output.

Test Plan:
1. MIN_FRAME_BYTES=1. Preamble 7x0x55, SFD 0xD5, payload 0x31..0x39 ("123456789"), FCS 0x26,0x39,0xF4,0xCB -> 9 bytes 0x31..0x39 out, m_last on 0x39, m_good=1, crc_err_cnt=0.
2. Same frame with final FCS byte 0xCA -> same 9 bytes, m_good=0, stat_crc_err=1, crc_err_cnt=1.
3. Same frame with rx_er=1 for one cycle on payload byte 4 -> m_good=0, stat_rx_err=1, stat_crc_err=0.
4. Same frame plus one extra nibble 0x3 before rx_dv drops -> stat_align_err=1, stat_crc_err=0, m_good=0.
5. rst pulse during payload byte 5, rx_dv held high -> no m_valid or stat_done for that frame. A following good frame (scenario 1) is received with m_good=1.
6. Default params, valid-CRC frames of 60 and 1519 bytes -> stat_runt=1 and stat_too_long=1 respectively, m_good=0 for both. A 2-byte frame -> stat_done with stat_runt=1 and no m_valid.
